// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel deserialiser: hunts for COMMA at any bit phase, locks after LOCK_COUNT aligned commas.
// Optional feature: define SP_ERR_CNT_EN to add the saturating err_count output.
module serial_paralelo_sync #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_RUN    = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic             active,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
`ifdef SP_ERR_CNT_EN
  output logic [15:0]      err_count,
`endif
  output logic             word_tick
);

  localparam int BW      = $clog2(WIDTH);
  localparam int CW      = $clog2(LOCK_COUNT + 1);
  localparam int RW      = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;
  localparam bit RUN_LIM = (MAX_RUN > 0);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [CW-1:0]    comma_cnt, comma_cnt_nx;
  logic [RW-1:0]    run_cnt, run_cnt_nx;
  logic             active_nx, valid_nx, tick_nx;
  logic [WIDTH-1:0] data_nx;
  logic             is_comma, boundary;

  assign is_comma = (shreg == COMMA);
  assign boundary = (bit_cnt == '0);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      shreg     <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      run_cnt   <= '0;
      active    <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      word_tick <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= {shreg[WIDTH-2:0], data_in};
      bit_cnt   <= bit_cnt_nx;
      comma_cnt <= comma_cnt_nx;
      run_cnt   <= run_cnt_nx;
      active    <= active_nx;
      valid_out <= valid_nx;
      data_out  <= data_nx;
      word_tick <= tick_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = (bit_cnt == BW'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
    comma_cnt_nx = comma_cnt;
    run_cnt_nx   = run_cnt;
    active_nx    = active;
    valid_nx     = 1'b0;
    tick_nx      = 1'b0;
    data_nx      = data_out;
    case (state)
      HUNT: begin
        bit_cnt_nx = '0;
        if (is_comma) begin
          // the next incoming bit is already bit 1 of the following word
          bit_cnt_nx   = BW'(1);
          comma_cnt_nx = CW'(1);
          if (LOCK_COUNT == 1) begin
            state_nx   = LOCKED;
            active_nx  = 1'b1;
            run_cnt_nx = '0;
          end else begin
            state_nx = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (boundary) begin
          tick_nx = 1'b1;
          if (is_comma) begin
            comma_cnt_nx = comma_cnt + 1'b1;
            if (comma_cnt == CW'(LOCK_COUNT - 1)) begin
              state_nx   = LOCKED;
              active_nx  = 1'b1;
              run_cnt_nx = '0;
            end
          end else begin
            state_nx     = HUNT;
            comma_cnt_nx = '0;
            bit_cnt_nx   = '0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          tick_nx = 1'b1;
          if (is_comma) begin
            run_cnt_nx = '0;
          end else if (!RUN_LIM || (run_cnt < RW'(MAX_RUN))) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
            if (RUN_LIM) run_cnt_nx = run_cnt + 1'b1;
          end else begin
            // run too long without a comma: drop the word and re-hunt
            state_nx     = HUNT;
            active_nx    = 1'b0;
            bit_cnt_nx   = '0;
            comma_cnt_nx = '0;
            run_cnt_nx   = '0;
          end
        end
      end
      default: state_nx = HUNT;
    endcase
  end

`ifdef SP_ERR_CNT_EN
  // every exit back to HUNT is either an alignment abort or a lock loss
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset)
      err_count <= '0;
    else if ((state != HUNT) && (state_nx == HUNT) && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Directed bench for serial_paralelo_sync: stimulus pushes expected words, a monitor pops them on valid_out.
module tb_serial_paralelo_sync;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic       active, valid_out, word_tick;
  logic [7:0] data_out;
`ifdef SP_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_sync #(
    .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .MAX_RUN(16)
  ) dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .data_in(data_in),
    .active(active),
    .valid_out(valid_out),
    .data_out(data_out),
`ifdef SP_ERR_CNT_EN
    .err_count(err_count),
`endif
    .word_tick(word_tick)
  );

  int         n_pass = 0, n_total = 0;
  int         n_valid = 0, n_pushed = 0;
  int         ticks = 0, cyc = 0, last_tick = -1;
  bit         tick_chk = 1'b0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [7:0] w);
    sb_q.push_back(w);
    n_pushed++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_32f);
      data_in = b[i];
    end
  endtask

  // active checked one and two cycles after the previous byte's last bit
  task automatic send_chk(input logic [7:0] b, input string name, input logic e1, input logic e2);
    fork
      send_byte(b);
      begin
        @(negedge clk_32f);
        chk({name, "_t1"}, 32'(active), 32'(e1));
        @(negedge clk_32f);
        chk({name, "_t2"}, 32'(active), 32'(e2));
      end
    join
  endtask

  always @(posedge clk_32f) cyc <= cyc + 1;

  always @(negedge clk_32f) begin
    if (!reset) begin
      if (word_tick) begin
        ticks++;
        if (tick_chk && last_tick >= 0) chk("tick_spacing", cyc - last_tick, 8);
        last_tick = cyc;
      end
      if (!tick_chk) last_tick = -1;
      if (valid_out) begin
        n_valid++;
        if (sb_q.size() == 0) chk("valid_unexpected", 32'(valid_out), 32'd0);
        else begin
          exp_w = sb_q.pop_front();
          chk("data_out", 32'(data_out), 32'(exp_w));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (3) @(negedge clk_32f);
    chk("rst_active", 32'(active), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_tick", 32'(word_tick), 0);
    reset = 1'b0;

    // 1: four aligned commas lock; ALIGN ticks only at the 2nd..4th comma
    ticks    = 0;
    tick_chk = 1'b1;
    repeat (4) send_byte(8'hBC);
    push(8'hA5);
    send_chk(8'hA5, "lock_latency", 1'b0, 1'b1);
    chk("align_ticks", 32'(ticks), 3);

    // 2: data, idle comma, data
    push(8'h3C);
    fork
      send_byte(8'h3C);
      begin
        @(negedge clk_32f);
        chk("valid_early", 32'(valid_out), 0);
        @(negedge clk_32f);
        chk("valid_latency", 32'(valid_out), 1);
        chk("first_word", 32'(data_out), 32'hA5);
      end
    join
    send_byte(8'hBC);
    push(8'h7E);
    fork
      send_byte(8'h7E);
      begin
        repeat (2) @(negedge clk_32f);
        chk("idle_hold", 32'(data_out), 32'h3C);
        chk("idle_novalid", 32'(valid_out), 0);
        chk("idle_tick", 32'(word_tick), 1);
      end
    join
    send_byte(8'hBC);
    chk("drain_t2", 32'(sb_q.size()), 0);

    // 6: asynchronous reset mid-word while locked
    chk("pre_rst_active", 32'(active), 1);
    chk("pre_rst_data", 32'(data_out), 32'h7E);
    tick_chk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_32f);
      data_in = ~i[0];
    end
    #2 reset = 1'b1;
    #1;
    chk("async_active", 32'(active), 0);
    chk("async_valid", 32'(valid_out), 0);
    chk("async_data", 32'(data_out), 0);
    repeat (2) @(negedge clk_32f);
    reset = 1'b0;

    // 3: three junk bits shift the word phase, then a fresh lock
    @(negedge clk_32f); data_in = 1'b1;
    @(negedge clk_32f); data_in = 1'b0;
    @(negedge clk_32f); data_in = 1'b1;
    repeat (3) send_byte(8'hBC);
    send_chk(8'hBC, "relock_3bc", 1'b0, 1'b0);
    push(8'h5A);
    send_chk(8'h5A, "relock_4bc", 1'b0, 1'b1);
    send_byte(8'hBC);
    chk("drain_t3", 32'(sb_q.size()), 0);

    // 5: 16 words delivered, 17th discarded and lock dropped
    tick_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      send_byte(8'(i));
    end
    send_byte(8'h10);
    send_chk(8'hBC, "run_unlock", 1'b1, 1'b0);
    tick_chk = 1'b0;
    chk("drain_t5", 32'(sb_q.size()), 0);
`ifdef SP_ERR_CNT_EN
    chk("err_after_unlock", 32'(err_count), 1);
`endif

    // 4: BC, BC, 55 aborts alignment; then re-hunt and lock
    send_byte(8'hBC);
    send_byte(8'h55);
    send_chk(8'hBC, "abort_55", 1'b0, 1'b0);
`ifdef SP_ERR_CNT_EN
    chk("err_after_abort", 32'(err_count), 2);
`endif
    repeat (3) send_byte(8'hBC);
    push(8'h3C);
    send_chk(8'h3C, "relock_abort", 1'b0, 1'b1);
    send_byte(8'hBC);
    chk("drain_t4", 32'(sb_q.size()), 0);
    chk("valid_pulses", 32'(n_valid), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
